// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq accumulator sequencer: opcode
// constants, FSM state encoding, flag bit positions and ALU selects.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DAA1 = 2'd2,
        DAA2 = 2'd3
    } stateT;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBB = 4'd3;
    localparam logic [3:0] OP_ANA = 4'd4;
    localparam logic [3:0] OP_XRA = 4'd5;
    localparam logic [3:0] OP_ORA = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd7;
    localparam logic [3:0] OP_INR = 4'd8;
    localparam logic [3:0] OP_DCR = 4'd9;
    localparam logic [3:0] OP_DAA = 4'd10;
    localparam logic [3:0] OP_LDA = 4'd11;
    localparam logic [3:0] OP_STC = 4'd12;
    localparam logic [3:0] OP_CMC = 4'd13;
    localparam logic [3:0] OP_CMA = 4'd14;
    localparam logic [3:0] OP_NOP = 4'd15;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b010;

    localparam int FLAG_S  = 7;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_AC = 4;
    localparam int FLAG_P  = 2;
    localparam int FLAG_C  = 0;

    // Implemented flag bits; bits 5, 3 and 1 always read as zero.
    localparam logic [7:0] FLAG_MASK     = 8'hD5;
    // Same set without carry, for ops that keep the old carry.
    localparam logic [7:0] FLAG_MASK_NOC = 8'hD4;

    // Ops 0-6 map straight onto the ALU select.
    function automatic logic isAluOp(input logic [3:0] op);
        return (op <= OP_ORA);
    endfunction

endpackage

// File: rtl/alu_seq.sv
// alu_seq: accumulator/flag sequencer around an external 8-bit ALU.
// Ports:
//   iClk, iRst          clock, synchronous active-high reset
//   iOpV/oOpR           op handshake (ready only in IDLE)
//   iOp, iData          opcode and operand/load data
//   oAcc, oFlg, oDone   accumulator, flag register, completion pulse
//   oAluS/A/B/F         drive to the ALU (all zero in IDLE)
//   iAluY, iAluF        ALU result and result flags
//
// state | meaning
// IDLE  | ready, waiting for iOpV
// EXEC  | single-pass op, write at end of cycle
// DAA1  | decimal adjust, low-nibble correction pass
// DAA2  | decimal adjust, high-nibble correction pass
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iOpV,
    output logic       oOpR,
    input  logic [3:0] iOp,
    input  logic [7:0] iData,
    output logic [7:0] oAcc,
    output logic [7:0] oFlg,
    output logic       oDone,
    output logic [2:0] oAluS,
    output logic [7:0] oAluA,
    output logic [7:0] oAluB,
    output logic [7:0] oAluF,
    input  logic [7:0] iAluY,
    input  logic [7:0] iAluF
);

    stateT      state;
    logic [3:0] opReg;
    logic [7:0] dataReg;
    logic       ac1;
    logic       upper;

    logic daaLow;
    logic daaHigh;

    // Low correction is decided from the accumulator at accept; high
    // correction from the pass-1 result and carry as DAA1 ends.
    assign daaLow  = (oAcc[3:0] > 4'd9) || oFlg[FLAG_AC];
    assign daaHigh = (iAluY[7:4] > 4'd9) || oFlg[FLAG_C] || iAluF[FLAG_C];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            oOpR    <= 1'b1;
            oDone   <= 1'b0;
            oAcc    <= 8'h00;
            oFlg    <= 8'h00;
            opReg   <= OP_NOP;
            dataReg <= 8'h00;
            ac1     <= 1'b0;
            upper   <= 1'b0;
            oAluS   <= 3'b000;
            oAluA   <= 8'h00;
            oAluB   <= 8'h00;
            oAluF   <= 8'h00;
        end else begin
            oDone <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (iOpV) begin
                        opReg   <= iOp;
                        dataReg <= iData;
                        oOpR    <= 1'b0;
                        if (iOp == OP_DAA) begin
                            state <= DAA1;
                            oAluS <= ALU_ADD;
                            oAluA <= oAcc;
                            oAluB <= daaLow ? 8'h06 : 8'h00;
                            oAluF <= oFlg;
                        end else begin
                            state <= EXEC;
                            oAluA <= 8'h00;
                            oAluB <= 8'h00;
                            oAluF <= 8'h00;
                            oAluS <= 3'b000;
                            if (isAluOp(iOp) || iOp == OP_CMP) begin
                                oAluS <= (iOp == OP_CMP) ? ALU_SUB : iOp[2:0];
                                oAluA <= oAcc;
                                oAluB <= iData;
                                oAluF <= oFlg;
                            end else if (iOp == OP_INR || iOp == OP_DCR) begin
                                oAluS <= (iOp == OP_DCR) ? ALU_SUB : ALU_ADD;
                                oAluA <= oAcc;
                                oAluB <= 8'h01;
                                oAluF <= oFlg;
                            end
                        end
                    end
                end
                EXEC: begin
                    if (isAluOp(opReg)) begin
                        oAcc <= iAluY;
                        oFlg <= iAluF & FLAG_MASK;
                    end else begin
                        case (opReg)
                            OP_CMP: oFlg <= iAluF & FLAG_MASK;
                            OP_INR, OP_DCR: begin
                                oAcc <= iAluY;
                                oFlg <= (iAluF & FLAG_MASK_NOC) | {7'b0, oFlg[FLAG_C]};
                            end
                            OP_LDA: oAcc <= dataReg;
                            OP_CMA: oAcc <= ~oAcc;
                            OP_STC: oFlg[FLAG_C] <= 1'b1;
                            OP_CMC: oFlg[FLAG_C] <= ~oFlg[FLAG_C];
                            default: ;
                        endcase
                    end
                    state <= IDLE;
                    oOpR  <= 1'b1;
                    oDone <= 1'b1;
                    oAluS <= 3'b000;
                    oAluA <= 8'h00;
                    oAluB <= 8'h00;
                    oAluF <= 8'h00;
                end
                DAA1: begin
                    oAcc  <= iAluY;
                    ac1   <= iAluF[FLAG_AC];
                    upper <= daaHigh;
                    oAluA <= iAluY;
                    oAluB <= daaHigh ? 8'h60 : 8'h00;
                    state <= DAA2;
                end
                DAA2: begin
                    oAcc <= iAluY;
                    oFlg <= (iAluF & 8'hC4)
                          | {3'b000, ac1, 4'b0000}
                          | {7'b0, upper | oFlg[FLAG_C]};
                    state <= IDLE;
                    oOpR  <= 1'b1;
                    oDone <= 1'b1;
                    oAluS <= 3'b000;
                    oAluA <= 8'h00;
                    oAluB <= 8'h00;
                    oAluF <= 8'h00;
                end
                default: begin
                    state <= IDLE;
                    oOpR  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       clk;
    logic       rst;
    logic       opV;
    logic       opR;
    logic [3:0] op;
    logic [7:0] data;
    logic [7:0] acc;
    logic [7:0] flg;
    logic       done;
    logic [2:0] aluS;
    logic [7:0] aluA;
    logic [7:0] aluB;
    logic [7:0] aluF;
    logic [7:0] aluY;
    logic [7:0] aluFo;

    int nChecks = 0;
    int nFails  = 0;

    alu_seq dut (
        .iClk(clk), .iRst(rst), .iOpV(opV), .oOpR(opR), .iOp(op), .iData(data),
        .oAcc(acc), .oFlg(flg), .oDone(done),
        .oAluS(aluS), .oAluA(aluA), .oAluB(aluB), .oAluF(aluF),
        .iAluY(aluY), .iAluF(aluFo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model. Unused flag bits are driven high so the
    // sequencer's masking is visible.
    logic [8:0] r;
    logic       ac;
    always_comb begin
        r  = 9'd0;
        ac = 1'b0;
        case (aluS)
            3'd0: begin
                r  = {1'b0, aluA} + {1'b0, aluB};
                ac = ({1'b0, aluA[3:0]} + {1'b0, aluB[3:0]}) > 5'd15;
            end
            3'd1: begin
                r  = {1'b0, aluA} + {1'b0, aluB} + {8'd0, aluF[0]};
                ac = ({1'b0, aluA[3:0]} + {1'b0, aluB[3:0]} + {4'd0, aluF[0]}) > 5'd15;
            end
            3'd2: begin
                r  = {1'b0, aluA} - {1'b0, aluB};
                ac = aluA[3:0] < aluB[3:0];
            end
            3'd3: begin
                r  = {1'b0, aluA} - {1'b0, aluB} - {8'd0, aluF[0]};
                ac = {1'b0, aluA[3:0]} < ({1'b0, aluB[3:0]} + {4'd0, aluF[0]});
            end
            3'd4: r = {1'b0, aluA & aluB};
            3'd5: r = {1'b0, aluA ^ aluB};
            3'd6: r = {1'b0, aluA | aluB};
            default: r = 9'd0;
        endcase
    end
    assign aluY  = r[7:0];
    assign aluFo = {r[7], (r[7:0] == 8'h00), 1'b1, ac, 1'b1, ~^r[7:0], 1'b1, r[8]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        opV = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one op from IDLE; lat counts negedges after the accept edge
    // until oDone is seen (bounded).
    task automatic issue(input logic [3:0] o, input logic [7:0] d, output int lat);
        @(negedge clk);
        check("ready before accept", {31'b0, opR}, 32'd1);
        opV  = 1'b1;
        op   = o;
        data = d;
        @(posedge clk);
        #1 opV = 1'b0;
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] data;
        logic [7:0] acc;
        logic [7:0] flg;
        int         lat;
    } vecT;

    vecT vecs[20];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int n;
        logic seenDone;

        rst  = 1'b1;
        opV  = 1'b0;
        op   = 4'd0;
        data = 8'h00;

        vecs[0]  = '{OP_LDA, 8'h7F, 8'h7F, 8'h00, 2};
        vecs[1]  = '{OP_STC, 8'h00, 8'h7F, 8'h01, 2};
        vecs[2]  = '{OP_INR, 8'h00, 8'h80, 8'h91, 2};
        vecs[3]  = '{OP_LDA, 8'hFF, 8'hFF, 8'h91, 2};
        vecs[4]  = '{OP_ADD, 8'h01, 8'h00, 8'h55, 2};
        vecs[5]  = '{OP_ADC, 8'h10, 8'h11, 8'h04, 2};
        vecs[6]  = '{OP_LDA, 8'h05, 8'h05, 8'h04, 2};
        vecs[7]  = '{OP_CMP, 8'h06, 8'h05, 8'h95, 2};
        vecs[8]  = '{OP_SBB, 8'h01, 8'h03, 8'h04, 2};
        vecs[9]  = '{OP_SUB, 8'h04, 8'hFF, 8'h95, 2};
        vecs[10] = '{OP_ANA, 8'h0F, 8'h0F, 8'h04, 2};
        vecs[11] = '{OP_XRA, 8'hFF, 8'hF0, 8'h84, 2};
        vecs[12] = '{OP_ORA, 8'h0F, 8'hFF, 8'h84, 2};
        vecs[13] = '{OP_DCR, 8'h00, 8'hFE, 8'h80, 2};
        vecs[14] = '{OP_CMC, 8'h00, 8'hFE, 8'h81, 2};
        vecs[15] = '{OP_CMA, 8'h00, 8'h01, 8'h81, 2};
        vecs[16] = '{OP_NOP, 8'h00, 8'h01, 8'h81, 2};
        vecs[17] = '{OP_DCR, 8'h00, 8'h00, 8'h45, 2};
        vecs[18] = '{OP_INR, 8'h00, 8'h01, 8'h01, 2};
        vecs[19] = '{OP_DAA, 8'h00, 8'h61, 8'h01, 3};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset acc", {24'b0, acc}, 32'h00);
        check("reset flg", {24'b0, flg}, 32'h00);
        check("reset ready", {31'b0, opR}, 32'd1);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset alu bus", {5'b0, aluS, aluA, aluB, aluF}, 32'h0);

        // Directed table, run as one dependent sequence
        for (int i = 0; i < 20; i++) begin
            issue(vecs[i].op, vecs[i].data, lat);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d acc", i), {24'b0, acc}, {24'b0, vecs[i].acc});
            check($sformatf("vec%0d flg", i), {24'b0, flg}, {24'b0, vecs[i].flg});
            check($sformatf("vec%0d idle alu bus", i), {5'b0, aluS, aluA, aluB, aluF}, 32'h0);
            @(negedge clk);
            check($sformatf("vec%0d done pulse width", i), {31'b0, done}, 32'd0);
        end

        // DAA with low and high correction, iOpV held high throughout
        doReset();
        issue(OP_LDA, 8'h9B, lat);
        check("daa pre acc", {24'b0, acc}, 32'h9B);
        @(negedge clk);
        opV  = 1'b1;
        op   = OP_DAA;
        data = 8'h00;
        @(posedge clk);
        #1;
        op   = OP_LDA;
        data = 8'h55;
        n = 0;
        while (n < 8) begin
            @(negedge clk);
            n++;
            if (done) break;
            check($sformatf("daa busy ready c%0d", n), {31'b0, opR}, 32'd0);
        end
        opV = 1'b0;
        check("daa latency", n, 3);
        check("daa acc", {24'b0, acc}, 32'h01);
        check("daa flg", {24'b0, flg}, 32'h11);
        @(negedge clk);
        @(negedge clk);
        check("daa held op ignored acc", {24'b0, acc}, 32'h01);

        // Reset during DAA1 aborts the op
        issue(OP_LDA, 8'h9B, lat);
        @(negedge clk);
        opV = 1'b1;
        op  = OP_DAA;
        @(posedge clk);
        #1;
        opV = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seenDone = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) seenDone = 1'b1;
        end
        check("abort no done", {31'b0, seenDone}, 32'd0);
        check("abort acc", {24'b0, acc}, 32'h00);
        check("abort flg", {24'b0, flg}, 32'h00);
        check("abort ready", {31'b0, opR}, 32'd1);
        issue(OP_LDA, 8'h42, lat);
        check("post abort latency", lat, 2);
        check("post abort acc", {24'b0, acc}, 32'h42);

        // Reset wins over a simultaneous accept
        @(negedge clk);
        rst  = 1'b1;
        opV  = 1'b1;
        op   = OP_LDA;
        data = 8'h33;
        @(posedge clk);
        #1;
        rst = 1'b0;
        opV = 1'b0;
        seenDone = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) seenDone = 1'b1;
        end
        check("rst priority no done", {31'b0, seenDone}, 32'd0);
        check("rst priority acc", {24'b0, acc}, 32'h00);
        check("rst priority ready", {31'b0, opR}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
